// File: rtl/muldiv_pkg.sv
// Shared types and defaults for the muldiv issue/writeback sequencer.
// Optional same-cycle result bypass is enabled by defining MULDIV_SEQ_BYPASS_EN.
package muldiv_pkg;

  localparam int MD_LATENCY_DEFAULT = 2;
  localparam int MD_XLEN_DEFAULT    = 32;

  typedef struct packed {
    logic       valid;
    logic       killed;
    logic [4:0] rd;
  } md_tag_t;

  typedef struct packed {
    logic [4:0]                 rd;
    logic [MD_XLEN_DEFAULT-1:0] data;
  } md_wb_t;

  // A tag still owns a credit and a hazard while valid and not flushed.
  function automatic logic tag_live(input md_tag_t t);
    return t.valid & ~t.killed;
  endfunction

endpackage

// File: rtl/muldiv_wb_fifo.sv
// Writeback result FIFO: circular buffer with per-entry valid/rd taps so the
// sequencer can check register hazards against buffered results.
module muldiv_wb_fifo #(
  parameter int DEPTH = 2,
  parameter int XLEN  = 32,
  parameter int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  flush_i,
  input  logic                  push_i,
  input  logic                  pop_i,
  input  logic [4:0]            rd_i,
  input  logic [XLEN-1:0]       data_i,
  output logic                  full_o,
  output logic                  empty_o,
  output logic [CNT_W-1:0]      count_o,
  output logic [4:0]            head_rd_o,
  output logic [XLEN-1:0]       head_data_o,
  output logic [DEPTH-1:0]      ent_valid_o,
  output logic [DEPTH-1:0][4:0] ent_rd_o
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [4:0]       rd_mem   [DEPTH];
  logic [XLEN-1:0]  data_mem [DEPTH];
  logic [DEPTH-1:0] valid_q, valid_d;
  logic [PTR_W-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             do_push, do_pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign full_o  = (count_q == CNT_W'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign do_pop  = pop_i & ~empty_o;
  assign do_push = push_i & (~full_o | do_pop);

  // Head is forced to zero when empty so the uninitialised storage never leaks out.
  assign head_rd_o   = empty_o ? '0 : rd_mem[rptr_q];
  assign head_data_o = empty_o ? '0 : data_mem[rptr_q];
  assign ent_valid_o = valid_q;

  always_comb begin
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    valid_d = valid_q;
    for (int i = 0; i < DEPTH; i++) ent_rd_o[i] = rd_mem[i];
    if (flush_i) begin
      wptr_d  = '0;
      rptr_d  = '0;
      count_d = '0;
      valid_d = '0;
    end else begin
      if (do_pop) begin
        valid_d[rptr_q] = 1'b0;
        rptr_d          = ptr_inc(rptr_q);
      end
      if (do_push) begin
        valid_d[wptr_q] = 1'b1;
        wptr_d          = ptr_inc(wptr_q);
      end
      case ({do_push, do_pop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  // NOTE: sequential state is updated only with non-blocking assignments.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      valid_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
      valid_q <= valid_d;
    end
  end

  // NOTE: payload storage is deliberately not reset; valid bits and the empty gate guard it.
  always_ff @(posedge clk_i) begin
    if (do_push && !flush_i) begin
      rd_mem[wptr_q]   <= rd_i;
      data_mem[wptr_q] <= data_i;
    end
  end

endmodule

// File: rtl/muldiv_seq.sv
// Issue/writeback sequencer for the fixed-latency muldiv unit: credits, tag pipe,
// hazards and buffered writeback. Define MULDIV_SEQ_BYPASS_EN for same-cycle bypass.
module muldiv_seq
  import muldiv_pkg::*;
#(
  parameter int XLEN       = 32,
  parameter int MD_LATENCY = MD_LATENCY_DEFAULT,
  parameter int BUF_DEPTH  = 2
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            req_valid_i,
  output logic            req_ready_o,
  input  logic [4:0]      req_rd_i,
  input  logic            flush_i,
  input  logic [4:0]      chk_rs1_i,
  input  logic [4:0]      chk_rs2_i,
  output logic            hazard_o,
  output logic            md_issue_o,
  input  logic            md_valid_i,
  input  logic [XLEN-1:0] md_result_i,
  output logic            wb_valid_o,
  input  logic            wb_ready_i,
  output logic [4:0]      wb_rd_o,
  output logic [XLEN-1:0] wb_data_o,
  output logic            err_o
);

  localparam int CNT_W = $clog2(BUF_DEPTH + 1);

  md_tag_t                  tag_q [MD_LATENCY];
  md_tag_t                  tag_d [MD_LATENCY];
  md_tag_t                  last_tag;
  logic                     err_q, err_d;
  logic                     fire, live_result, fifo_push, fifo_pop, bypass;
  logic                     fifo_full, fifo_empty;
  logic [CNT_W-1:0]         fifo_count;
  logic [4:0]               head_rd;
  logic [XLEN-1:0]          head_data;
  logic [BUF_DEPTH-1:0]     ent_valid;
  logic [BUF_DEPTH-1:0][4:0] ent_rd;
  int                       live_cnt;

  assign last_tag   = tag_q[MD_LATENCY-1];
  assign fire       = req_valid_i & req_ready_o;
  assign md_issue_o = fire;
  // A result arriving in the flush cycle belongs to a killed op as well.
  assign live_result = md_valid_i & tag_live(last_tag) & (last_tag.rd != 5'd0) & ~flush_i;
  assign fifo_pop    = ~fifo_empty & wb_ready_i;

`ifdef MULDIV_SEQ_BYPASS_EN
  assign bypass     = fifo_empty & live_result;
  assign fifo_push  = live_result & ~(bypass & wb_ready_i);
  assign wb_valid_o = ~fifo_empty | bypass;
  assign wb_rd_o    = bypass ? last_tag.rd : head_rd;
  assign wb_data_o  = bypass ? md_result_i : head_data;
`else
  assign bypass     = 1'b0;
  assign fifo_push  = live_result;
  assign wb_valid_o = ~fifo_empty;
  assign wb_rd_o    = head_rd;
  assign wb_data_o  = head_data;
`endif

  always_comb begin
    tag_d[0] = fire ? '{valid: 1'b1, killed: 1'b0, rd: req_rd_i} : '0;
    for (int i = 1; i < MD_LATENCY; i++) tag_d[i] = tag_q[i-1];
    // Flushed tags keep shifting so later results still line up with the unit.
    for (int i = 0; i < MD_LATENCY; i++)
      if (flush_i && tag_d[i].valid) tag_d[i].killed = 1'b1;
    err_d = err_q | (md_valid_i & ~last_tag.valid);
  end

  always_comb begin
    live_cnt = 0;
    hazard_o = 1'b0;
    for (int i = 0; i < MD_LATENCY; i++) begin
      live_cnt += int'(tag_live(tag_q[i]));
      if (tag_live(tag_q[i]) &&
          ((chk_rs1_i != 5'd0 && chk_rs1_i == tag_q[i].rd) ||
           (chk_rs2_i != 5'd0 && chk_rs2_i == tag_q[i].rd)))
        hazard_o = 1'b1;
    end
    for (int j = 0; j < BUF_DEPTH; j++)
      if (ent_valid[j] &&
          ((chk_rs1_i != 5'd0 && chk_rs1_i == ent_rd[j]) ||
           (chk_rs2_i != 5'd0 && chk_rs2_i == ent_rd[j])))
        hazard_o = 1'b1;
    req_ready_o = ~flush_i & ((live_cnt + int'(fifo_count)) < BUF_DEPTH);
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      for (int i = 0; i < MD_LATENCY; i++) tag_q[i] <= '0;
      err_q <= 1'b0;
    end else begin
      for (int i = 0; i < MD_LATENCY; i++) tag_q[i] <= tag_d[i];
      err_q <= err_d;
    end
  end

  assign err_o = err_q;

  muldiv_wb_fifo #(
    .DEPTH (BUF_DEPTH),
    .XLEN  (XLEN),
    .CNT_W (CNT_W)
  ) u_fifo (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .flush_i     (flush_i),
    .push_i      (fifo_push),
    .pop_i       (fifo_pop),
    .rd_i        (last_tag.rd),
    .data_i      (md_result_i),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty),
    .count_o     (fifo_count),
    .head_rd_o   (head_rd),
    .head_data_o (head_data),
    .ent_valid_o (ent_valid),
    .ent_rd_o    (ent_rd)
  );

  // Full is implied by the credit check; kept visible for debug only.
  logic unused_ok;
  assign unused_ok = fifo_full | bypass;

endmodule

// File: tb/tb_muldiv_seq.sv
// Directed bench for muldiv_seq: drives the unit side by hand and checks
// issue, credit, hazard, flush, error and writeback timing.
module tb_muldiv_seq;

`ifdef MULDIV_SEQ_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        req_valid_i, req_ready_o;
  logic [4:0]  req_rd_i;
  logic        flush_i;
  logic [4:0]  chk_rs1_i, chk_rs2_i;
  logic        hazard_o, md_issue_o, md_valid_i;
  logic [31:0] md_result_i;
  logic        wb_valid_o, wb_ready_i;
  logic [4:0]  wb_rd_o;
  logic [31:0] wb_data_o;
  logic        err_o;

  int vectors     = 0;
  int miscompares = 0;

  always #5 clk_i = ~clk_i;

  muldiv_seq #(.XLEN(32), .MD_LATENCY(2), .BUF_DEPTH(2)) dut (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .req_valid_i (req_valid_i),
    .req_ready_o (req_ready_o),
    .req_rd_i    (req_rd_i),
    .flush_i     (flush_i),
    .chk_rs1_i   (chk_rs1_i),
    .chk_rs2_i   (chk_rs2_i),
    .hazard_o    (hazard_o),
    .md_issue_o  (md_issue_o),
    .md_valid_i  (md_valid_i),
    .md_result_i (md_result_i),
    .wb_valid_o  (wb_valid_o),
    .wb_ready_i  (wb_ready_i),
    .wb_rd_o     (wb_rd_o),
    .wb_data_o   (wb_data_o),
    .err_o       (err_o)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Inputs change just after the rising edge; outputs are sampled on the falling edge.
  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic sample();
    @(negedge clk_i);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_ready"}, req_ready_o, 1);
    check({tag, "_issue"}, md_issue_o, 0);
    check({tag, "_wbv"},   wb_valid_o, 0);
    check({tag, "_wbrd"},  wb_rd_o, 0);
    check({tag, "_wbdat"}, wb_data_o, 0);
    check({tag, "_haz"},   hazard_o, 0);
    check({tag, "_err"},   err_o, 0);
  endtask

  initial begin
    rst_ni = 1'b0; req_valid_i = 1'b0; req_rd_i = '0; flush_i = 1'b0;
    chk_rs1_i = '0; chk_rs2_i = '0; md_valid_i = 1'b0; md_result_i = '0;
    wb_ready_i = 1'b1;
    tick(); tick();
    rst_ni = 1'b1;
    sample();
    check_reset_outputs("rst");

    // Single op rd=5, result 6.
    tick(); req_valid_i = 1'b1; req_rd_i = 5'd5; chk_rs1_i = 5'd5;
    sample(); check("t1_issue", md_issue_o, 1); check("t1_haz_T0", hazard_o, 0);
    tick(); req_valid_i = 1'b0;
    sample(); check("t1_haz_T1", hazard_o, 1);
    tick(); md_valid_i = 1'b1; md_result_i = 32'h0000_0006;
    sample(); check("t1_haz_T2", hazard_o, 1); check("t1_wbv_T2", wb_valid_o, BYP);
    check("t1_wbdat_T2", wb_data_o, BYP ? 32'h6 : 32'h0);
    tick(); md_valid_i = 1'b0;
    sample(); check("t1_wbv_T3", wb_valid_o, !BYP); check("t1_wbrd_T3", wb_rd_o, BYP ? 0 : 5);
    check("t1_wbdat_T3", wb_data_o, BYP ? 32'h0 : 32'h6); check("t1_haz_T3", hazard_o, !BYP);
    tick();
    sample(); check("t1_haz_T4", hazard_o, 0); check("t1_wbv_T4", wb_valid_o, 0);

    // Credit stall: three back-to-back with writeback blocked.
    tick(); wb_ready_i = 1'b0; req_valid_i = 1'b1; req_rd_i = 5'd1; chk_rs1_i = '0;
    sample(); check("t2_ready_A0", req_ready_o, 1); check("t2_issue_A0", md_issue_o, 1);
    tick(); req_rd_i = 5'd2;
    sample(); check("t2_issue_A1", md_issue_o, 1);
    tick(); req_rd_i = 5'd3; md_valid_i = 1'b1; md_result_i = 32'h11;
    sample(); check("t2_ready_A2", req_ready_o, 0); check("t2_issue_A2", md_issue_o, 0);
    tick(); md_result_i = 32'h22;
    sample(); check("t2_ready_A3", req_ready_o, 0);
    tick(); md_valid_i = 1'b0;
    sample(); check("t2_wbv_A4", wb_valid_o, 1); check("t2_wbrd_A4", wb_rd_o, 1);
    check("t2_wbdat_A4", wb_data_o, 32'h11); check("t2_ready_A4", req_ready_o, 0);
    tick(); wb_ready_i = 1'b1;
    sample(); check("t2_wbrd_A5", wb_rd_o, 1); check("t2_issue_A5", md_issue_o, 0);
    tick();
    sample(); check("t2_issue_A6", md_issue_o, 1); check("t2_wbrd_A6", wb_rd_o, 2);
    check("t2_wbdat_A6", wb_data_o, 32'h22);
    tick(); req_valid_i = 1'b0;
    sample(); check("t2_wbv_A7", wb_valid_o, 0);
    tick(); md_valid_i = 1'b1; md_result_i = 32'h33;
    sample(); check("t2_wbv_A8", wb_valid_o, BYP); check("t2_wbrd_A8", wb_rd_o, BYP ? 3 : 0);
    tick(); md_valid_i = 1'b0;
    sample(); check("t2_wbv_A9", wb_valid_o, !BYP); check("t2_wbrd_A9", wb_rd_o, BYP ? 0 : 3);
    check("t2_wbdat_A9", wb_data_o, BYP ? 32'h0 : 32'h33);

    // Flush kills rd=7 in flight.
    tick(); req_valid_i = 1'b1; req_rd_i = 5'd7; chk_rs2_i = 5'd7;
    sample(); check("t3_issue", md_issue_o, 1);
    tick(); req_valid_i = 1'b0; flush_i = 1'b1;
    sample(); check("t3_haz_T1", hazard_o, 1); check("t3_ready_T1", req_ready_o, 0);
    tick(); flush_i = 1'b0; md_valid_i = 1'b1; md_result_i = 32'h77;
    sample(); check("t3_haz_T2", hazard_o, 0); check("t3_wbv_T2", wb_valid_o, 0);
    tick(); md_valid_i = 1'b0;
    sample(); check("t3_wbv_T3", wb_valid_o, 0); check("t3_err", err_o, 0);
    check("t3_ready_T3", req_ready_o, 1);

    // rd=0 ops are discarded and return their credit.
    tick(); req_valid_i = 1'b1; req_rd_i = 5'd0; chk_rs1_i = 5'd0; chk_rs2_i = 5'd0;
    sample(); check("t4_issue_T0", md_issue_o, 1);
    tick();
    sample(); check("t4_issue_T1", md_issue_o, 1); check("t4_haz_T1", hazard_o, 0);
    tick(); req_valid_i = 1'b0; md_valid_i = 1'b1; md_result_i = 32'h99;
    sample(); check("t4_ready_T2", req_ready_o, 0); check("t4_wbv_T2", wb_valid_o, 0);
    tick();
    sample(); check("t4_ready_T3", req_ready_o, 1); check("t4_wbv_T3", wb_valid_o, 0);
    tick(); md_valid_i = 1'b0;
    sample(); check("t4_wbv_T4", wb_valid_o, 0); check("t4_err", err_o, 0);

    // Orphan result sets sticky error.
    tick(); md_valid_i = 1'b1; md_result_i = 32'hdead_beef;
    tick(); md_valid_i = 1'b0;
    sample(); check("t5_err_E1", err_o, 1); check("t5_wbv_E1", wb_valid_o, 0);
    tick(); tick();
    sample(); check("t5_err_E3", err_o, 1);

    // Reset mid-operation with a buffered result and a tag in flight.
    tick(); req_valid_i = 1'b1; req_rd_i = 5'd9; chk_rs1_i = 5'd9; wb_ready_i = 1'b0;
    tick(); req_valid_i = 1'b0;
    tick(); md_valid_i = 1'b1; md_result_i = 32'h55;
    tick(); md_valid_i = 1'b0; req_valid_i = 1'b1; req_rd_i = 5'd10;
    sample(); check("t5_wbv_R3", wb_valid_o, 1); check("t5_haz_R3", hazard_o, 1);
    check("t5_err_R3", err_o, 1);
    tick(); req_valid_i = 1'b0; rst_ni = 1'b0;
    tick(); rst_ni = 1'b1;
    sample();
    check_reset_outputs("t5_rst");

    // Plain single op with 0x1234_5678: bypass timing versus buffered timing.
    tick(); wb_ready_i = 1'b1; req_valid_i = 1'b1; req_rd_i = 5'd3; chk_rs1_i = '0;
    tick(); req_valid_i = 1'b0;
    tick(); md_valid_i = 1'b1; md_result_i = 32'h1234_5678;
    sample(); check("t6_wbv_T2", wb_valid_o, BYP);
    check("t6_wbdat_T2", wb_data_o, BYP ? 32'h1234_5678 : 32'h0);
    tick(); md_valid_i = 1'b0;
    sample(); check("t6_wbv_T3", wb_valid_o, !BYP);
    check("t6_wbdat_T3", wb_data_o, BYP ? 32'h0 : 32'h1234_5678);
    tick();
    sample(); check("t6_wbv_T4", wb_valid_o, 0); check("t6_err", err_o, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
